// File: rtl/ysyx_22040127_iter_divider_pkg.sv
// Shared encodings for the iterative DIV/REM engine: op codes, FSM states and
// the iteration-counter width helper.
package ysyx_22040127_iter_divider_pkg;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    DIV_S_IDLE  = 2'd0,
    DIV_S_CALC  = 2'd1,
    DIV_S_FIXUP = 2'd2,
    DIV_S_DONE  = 2'd3
  } div_state_e;

  function automatic int div_cnt_w(input int xlen);
    return $clog2(xlen) + 1;
  endfunction

endpackage

// File: rtl/ysyx_22040127_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor if it fits, and report whether it did as the quotient bit.
module ysyx_22040127_div_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN:0]   rem_i,
  input  logic [XLEN-1:0] dvs_i,
  input  logic            bit_i,
  output logic [XLEN:0]   rem_o,
  output logic            q_o
);

  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] diff;

  assign shifted = {rem_i, bit_i};
  assign diff    = shifted - {2'b00, dvs_i};
  assign q_o     = ~diff[XLEN+1];
  assign rem_o   = q_o ? diff[XLEN:0] : shifted[XLEN:0];

endmodule

// File: rtl/ysyx_22040127_iter_divider.sv
// Iterative radix-2 restoring divider for div/divu/rem/remu and W forms.
// Operands are reduced to magnitudes on accept; signs are reapplied in FIXUP.
module ysyx_22040127_iter_divider
  import ysyx_22040127_iter_divider_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int TAG_W    = 5,
  parameter bit WORD_OPS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [1:0]       in_op,
  input  logic             in_word,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int CNT_W = div_cnt_w(XLEN);
  localparam bit WORD_EN = WORD_OPS && (XLEN == 64);
  localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W = XLEN'($signed(32'h8000_0000));

  function automatic logic [XLEN-1:0] wfix(input logic w, input logic [XLEN-1:0] v);
    return w ? XLEN'($signed(v[31:0])) : v;
  endfunction

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  quo_q, quo_d;   // dividend bits shift out, quotient bits shift in
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic [XLEN:0]    rem_q, rem_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d;
  logic             is_rem_q, is_rem_d, word_q, word_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [XLEN-1:0]  result_q, result_d;

  logic [XLEN:0]    step_rem;
  logic             step_q;

  logic             word_in, signed_in, rem_in, sa, sb, div0, ovf;
  logic [XLEN-1:0]  a_ext, b_ext, q_fix, r_fix;

  ysyx_22040127_div_step #(.XLEN(XLEN)) u_step (
    .rem_i (rem_q),
    .dvs_i (dvs_q),
    .bit_i (quo_q[XLEN-1]),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  always_comb begin
    word_in   = in_word & WORD_EN;
    signed_in = (in_op == DIV_OP_DIV) || (in_op == DIV_OP_REM);
    rem_in    = (in_op == DIV_OP_REM) || (in_op == DIV_OP_REMU);
    if (word_in) begin
      a_ext = signed_in ? XLEN'($signed(in_a[31:0])) : XLEN'(in_a[31:0]);
      b_ext = signed_in ? XLEN'($signed(in_b[31:0])) : XLEN'(in_b[31:0]);
    end else begin
      a_ext = in_a;
      b_ext = in_b;
    end
    sa   = signed_in & a_ext[XLEN-1];
    sb   = signed_in & b_ext[XLEN-1];
    div0 = (b_ext == '0);
    ovf  = signed_in && (b_ext == '1) && (a_ext == (word_in ? MIN_W : MIN_X));

    q_fix = qneg_q ? -quo_q : quo_q;
    r_fix = rneg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

    state_d  = state_q;
    cnt_d    = cnt_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    is_rem_d = is_rem_q;
    word_d   = word_q;
    tag_d    = tag_q;
    result_d = result_q;

    unique case (state_q)
      DIV_S_IDLE: begin
        if (in_valid) begin
          cnt_d    = '0;
          quo_d    = sa ? -a_ext : a_ext;
          dvs_d    = sb ? -b_ext : b_ext;
          rem_d    = '0;
          qneg_d   = sa ^ sb;
          rneg_d   = sa;
          is_rem_d = rem_in;
          word_d   = word_in;
          tag_d    = in_tag;
          if (div0) begin
            result_d = wfix(word_in, rem_in ? a_ext : '1);
            state_d  = DIV_S_DONE;
          end else if (ovf) begin
            result_d = wfix(word_in, rem_in ? '0 : a_ext);
            state_d  = DIV_S_DONE;
          end else begin
            state_d  = DIV_S_CALC;
          end
        end
      end
      DIV_S_CALC: begin
        quo_d = {quo_q[XLEN-2:0], step_q};
        rem_d = step_rem;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN-1)) state_d = DIV_S_FIXUP;
      end
      DIV_S_FIXUP: begin
        result_d = wfix(word_q, is_rem_q ? r_fix : q_fix);
        state_d  = DIV_S_DONE;
      end
      DIV_S_DONE: begin
        if (out_ready) state_d = DIV_S_IDLE;
      end
      default: state_d = DIV_S_IDLE;
    endcase

    // A kill wins in every state, including the accept cycle.
    if (flush) state_d = DIV_S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DIV_S_IDLE;
      cnt_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      is_rem_q <= 1'b0;
      word_q   <= 1'b0;
      tag_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      is_rem_q <= is_rem_d;
      word_q   <= word_d;
      tag_q    <= tag_d;
      result_q <= result_d;
    end
  end

  assign in_ready   = (state_q == DIV_S_IDLE);
  assign out_valid  = (state_q == DIV_S_DONE);
  assign busy       = (state_q != DIV_S_IDLE);
  assign out_result = result_q;
  assign out_tag    = tag_q;

endmodule

// File: tb/tb_ysyx_22040127_iter_divider.sv
// Directed and randomised checks of the iterative divider: results, tags,
// latency, hold under backpressure, flush and reset.
module tb_ysyx_22040127_iter_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [63:0] in_a, in_b;
  logic [1:0]  in_op;
  logic        in_word;
  logic [4:0]  in_tag;
  logic        flush;
  logic        out_valid, out_ready;
  logic [63:0] out_result;
  logic [4:0]  out_tag;
  logic        busy;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  tag;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;
  logic [4:0] tag_n = 5'd0;

  ysyx_22040127_iter_divider #(.XLEN(64), .TAG_W(5), .WORD_OPS(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .in_word    (in_word),
    .in_tag     (in_tag),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic run_op(input string name, input logic [63:0] a, input logic [63:0] b,
                        input logic [1:0] op, input logic w, input logic [63:0] exp,
                        input int exp_lat, input int hold);
    exp_t e;
    int   lat;
    logic held_ok;
    check({name, "/in_ready_before"}, 64'(in_ready), 64'd1);
    tag_n    = tag_n + 5'd1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    in_word  = w;
    in_tag   = tag_n;
    in_valid = 1'b1;
    sb.push_back('{res: exp, tag: tag_n});
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a     = ~a;
    in_b     = ~b;
    in_tag   = ~tag_n;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "/latency"}, 64'(lat), 64'(exp_lat));
    e = sb.pop_front();
    check({name, "/result"}, out_result, e.res);
    check({name, "/tag"}, 64'(out_tag), 64'(e.tag));
    if (hold > 0) begin
      held_ok = 1'b1;
      repeat (hold) begin
        @(posedge clk); #1;
        if (out_valid !== 1'b1 || out_result !== e.res || out_tag !== e.tag || in_ready !== 1'b0)
          held_ok = 1'b0;
      end
      check({name, "/hold_stable"}, 64'(held_ok), 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, "/idle_after"}, {62'd0, in_ready, out_valid}, 64'b10);
  endtask

  task automatic start_long_op();
    tag_n    = tag_n + 5'd1;
    in_a     = 64'hFFFF_FFFF_FFFF_FFFF;
    in_b     = 64'd3;
    in_op    = 2'b01;
    in_word  = 1'b0;
    in_tag   = tag_n;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("long_op/busy", 64'(busy), 64'd1);
  endtask

  task automatic expect_quiet(input string name);
    logic saw;
    saw = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
      if (out_valid) saw = 1'b1;
    end
    check({name, "/no_out_valid"}, 64'(saw), 64'd0);
  endtask

  initial begin
    logic [63:0]        a, b;
    logic signed [63:0] sa, sbv;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_word = 1'b0;
    in_tag = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset/in_ready", 64'(in_ready), 64'd1);
    check("reset/out_valid", 64'(out_valid), 64'd0);
    check("reset/busy", 64'(busy), 64'd0);
    check("reset/out_result", out_result, 64'd0);
    check("reset/out_tag", 64'(out_tag), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("divu_100_7", 64'd100, 64'd7, 2'b01, 1'b0, 64'd14, 66, 0);
    run_op("remu_100_7", 64'd100, 64'd7, 2'b11, 1'b0, 64'd2, 66, 0);
    run_op("div_m7_2", -64'sd7, 64'd2, 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 66, 0);
    run_op("rem_m7_2", -64'sd7, 64'd2, 2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 66, 0);
    run_op("rem_7_m2", 64'd7, -64'sd2, 2'b10, 1'b0, 64'd1, 66, 0);
    run_op("div_by0", 64'd5, 64'd0, 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    run_op("rem_by0", 64'h1234, 64'd0, 2'b10, 1'b0, 64'h1234, 1, 0);
    run_op("div_ovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1'b0,
           64'h8000_0000_0000_0000, 1, 0);
    run_op("rem_ovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 1'b0, 64'd0, 1, 0);
    run_op("divuw", 64'hFFFF_FFFF_8000_0000, 64'd1, 2'b01, 1'b1, 64'hFFFF_FFFF_8000_0000, 66, 0);
    run_op("divw_ovf", 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1'b1,
           64'hFFFF_FFFF_8000_0000, 1, 0);
    run_op("remw_by0", 64'd5, 64'd0, 2'b10, 1'b1, 64'd5, 1, 0);
    run_op("hold_divu", 64'd100, 64'd7, 2'b01, 1'b0, 64'd14, 66, 10);

    for (int i = 0; i < 4; i++) begin
      a = {$urandom, $urandom};
      b = (i % 2 == 1) ? {$urandom, $urandom} : 64'($urandom_range(1, 1000));
      if (b == 64'd0) b = 64'd1;
      run_op("rand_divu", a, b, 2'b01, 1'b0, a / b, 66, 0);
      run_op("rand_remu", a, b, 2'b11, 1'b0, a % b, 66, 0);
      sa  = $signed({$urandom, $urandom});
      sbv = (i % 2 == 1) ? $signed({$urandom, $urandom}) : -$signed(64'($urandom_range(2, 1000)));
      if (sbv == 64'sd0 || sbv == -64'sd1) sbv = 64'sd3;
      run_op("rand_div", sa, sbv, 2'b00, 1'b0, sa / sbv, 66, 0);
      run_op("rand_rem", sa, sbv, 2'b10, 1'b0, sa % sbv, 66, 0);
    end

    // A request presented together with flush must not be taken.
    in_a = 64'd9; in_b = 64'd3; in_op = 2'b01; in_word = 1'b0; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_accept/busy", 64'(busy), 64'd0);

    start_long_op();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush/in_ready", 64'(in_ready), 64'd1);
    expect_quiet("flush");
    run_op("divu_after_flush", 64'd9, 64'd3, 2'b01, 1'b0, 64'd3, 66, 0);

    start_long_op();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid/in_ready", 64'(in_ready), 64'd1);
    check("rst_mid/out_result", out_result, 64'd0);
    check("rst_mid/out_tag", 64'(out_tag), 64'd0);
    expect_quiet("rst_mid");
    run_op("divu_after_rst", 64'd9, 64'd3, 2'b01, 1'b0, 64'd3, 66, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
